regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_rr.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared core definitions: register-file geometry defaults and the legal
// write-width encodings used by both the writeback arbiter and the register file.
package regfile_write_arbiter_pkg;

    localparam int REG_NUMBER_DEFAULT = 32;
    localparam int REG_WIDTH_DEFAULT  = 32;

    typedef logic [3:0] wr_width_t;

    // Byte counts, so the value doubles as a byte-lane count.
    localparam wr_width_t WIDTH_BYTE = 4'd1;
    localparam wr_width_t WIDTH_HALF = 4'd2;
    localparam wr_width_t WIDTH_WORD = 4'd4;

    function automatic logic is_legal_width(input wr_width_t width);
        return (width == WIDTH_BYTE) || (width == WIDTH_HALF) || (width == WIDTH_WORD);
    endfunction

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Round-robin selector: one-hot grant to the first requester at or after ptr,
// wrapping back to index 0.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int PTR_WIDTH = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    logic found;

    // The first loop covers indices at or above ptr; the second only fires when
    // none of those asked, so it effectively scans the wrapped part 0..ptr-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter in front of the register file: round-robin grant, registered
// write port, destination-busy scoreboard and a sticky illegal-width flag.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int REG_NUMBER       = REG_NUMBER_DEFAULT,
    parameter int REG_ADDR_WIDTH   = $clog2(REG_NUMBER),
    parameter int REG_WIDTH_IN_BIT = REG_WIDTH_DEFAULT,
    parameter int NUM_REQ          = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*4-1:0]                 req_width,
    input  logic [NUM_REQ*REG_WIDTH_IN_BIT-1:0]  req_data,

    output logic                                 rf_write_enable,
    output logic [3:0]                           rf_write_width,
    output logic [REG_ADDR_WIDTH-1:0]            rf_write_reg_addr,
    output logic [REG_WIDTH_IN_BIT-1:0]          rf_write_data,

    input  logic                                 reserve_valid,
    input  logic [REG_ADDR_WIDTH-1:0]            reserve_addr,
    input  logic [REG_ADDR_WIDTH-1:0]            read_reg1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]            read_reg2_addr,
    output logic                                 reg1_busy,
    output logic                                 reg2_busy,
    output logic [REG_NUMBER-1:0]                busy_vector,

    input  logic                                 flush,
    output logic                                 width_error
);

    localparam int PTR_WIDTH = ptr_width(NUM_REQ);

    logic [PTR_WIDTH-1:0]        rr_ptr;
    logic [PTR_WIDTH-1:0]        rr_ptr_next;
    logic [NUM_REQ-1:0]          grant;
    logic                        handshake;

    logic [PTR_WIDTH-1:0]        sel_idx;
    logic [REG_ADDR_WIDTH-1:0]   sel_addr;
    wr_width_t                   sel_width;
    logic [REG_WIDTH_IN_BIT-1:0] sel_data;
    logic                        sel_legal;
    logic                        sel_write;

    logic [REG_NUMBER-1:0]       busy_next;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Gating here keeps a flush or reset from ever producing a handshake,
    // which in turn freezes rr_ptr and suppresses the next write.
    assign req_ready = (reset || flush) ? '0 : grant;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        sel_idx   = '0;
        sel_addr  = '0;
        sel_width = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_idx   = PTR_WIDTH'(i);
                sel_addr  = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_width = req_width[i*4 +: 4];
                sel_data  = req_data[i*REG_WIDTH_IN_BIT +: REG_WIDTH_IN_BIT];
            end
        end
    end

    assign rr_ptr_next = (sel_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_WIDTH'(1);
    assign sel_legal   = is_legal_width(sel_width);
    assign sel_write   = handshake && (sel_addr != '0) && sel_legal;

    // Clear before set so a same-cycle reservation of the retiring register wins.
    always_comb begin
        busy_next = busy_vector;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (handshake) begin
                busy_next[sel_addr] = 1'b0;
            end
            if (reserve_valid && (reserve_addr != '0)) begin
                busy_next[reserve_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr            <= '0;
            busy_vector       <= '0;
            width_error       <= 1'b0;
            rf_write_enable   <= 1'b0;
            rf_write_width    <= '0;
            rf_write_reg_addr <= '0;
            rf_write_data     <= '0;
        end else begin
            busy_vector     <= busy_next;
            rf_write_enable <= sel_write;
            if (handshake) begin
                rr_ptr            <= rr_ptr_next;
                rf_write_width    <= sel_width;
                rf_write_reg_addr <= sel_addr;
                rf_write_data     <= sel_data;
                if (!sel_legal) begin
                    width_error <= 1'b1;
                end
            end
        end
    end

    assign reg1_busy = (read_reg1_addr != '0) && busy_vector[read_reg1_addr];
    assign reg2_busy = (read_reg2_addr != '0) && busy_vector[read_reg2_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration order, scoreboard,
// dropped/illegal writes, flush and asynchronous reset.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int RN = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*4-1:0] req_width;
    logic [NR*DW-1:0] req_data;
    logic            rf_write_enable;
    logic [3:0]      rf_write_width;
    logic [AW-1:0]   rf_write_reg_addr;
    logic [DW-1:0]   rf_write_data;
    logic            reserve_valid;
    logic [AW-1:0]   reserve_addr;
    logic [AW-1:0]   read_reg1_addr;
    logic [AW-1:0]   read_reg2_addr;
    logic            reg1_busy;
    logic            reg2_busy;
    logic [RN-1:0]   busy_vector;
    logic            flush;
    logic            width_error;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(
        .REG_NUMBER       (RN),
        .REG_ADDR_WIDTH   (AW),
        .REG_WIDTH_IN_BIT (DW),
        .NUM_REQ          (NR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_width         (req_width),
        .req_data          (req_data),
        .rf_write_enable   (rf_write_enable),
        .rf_write_width    (rf_write_width),
        .rf_write_reg_addr (rf_write_reg_addr),
        .rf_write_data     (rf_write_data),
        .reserve_valid     (reserve_valid),
        .reserve_addr      (reserve_addr),
        .read_reg1_addr    (read_reg1_addr),
        .read_reg2_addr    (read_reg2_addr),
        .reg1_busy         (reg1_busy),
        .reg2_busy         (reg2_busy),
        .busy_vector       (busy_vector),
        .flush             (flush),
        .width_error       (width_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [3:0] w, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = a;
        req_width[i*4 +: 4]   = w;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic idle();
        req_valid     = '0;
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        flush         = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [3:0] w, input logic [DW-1:0] d);
        check({tag, "_en"},   rf_write_enable,   1'b1);
        check({tag, "_addr"}, rf_write_reg_addr, a);
        check({tag, "_wid"},  rf_write_width,    w);
        check({tag, "_data"}, rf_write_data,     d);
    endtask

    initial begin
        reset          = 1'b1;
        req_addr       = '0;
        req_width      = '0;
        req_data       = '0;
        read_reg1_addr = '0;
        read_reg2_addr = '0;
        idle();

        // Reset state, with requests already pending.
        set_req(0, 5'd5, 4'd4, 32'h5555_0005);
        set_req(1, 5'd6, 4'd4, 32'h6666_0006);
        set_req(2, 5'd7, 4'd4, 32'h7777_0007);
        #1;
        check("rst_ready", req_ready, 3'b000);
        tick();
        check("rst_en",    rf_write_enable, 1'b0);
        check("rst_busy",  busy_vector, 32'h0);
        check("rst_werr",  width_error, 1'b0);
        check("rst_addr",  rf_write_reg_addr, 5'd0);
        check("rst_data",  rf_write_data, 32'h0);

        // Round-robin: all three valid for three cycles.
        reset = 1'b0;
        #1;
        check("rr_c1_ready", req_ready, 3'b001);
        tick();
        check_write("rr_c2", 5'd5, 4'd4, 32'h5555_0005);
        check("rr_c2_ready", req_ready, 3'b010);
        tick();
        check_write("rr_c3", 5'd6, 4'd4, 32'h6666_0006);
        check("rr_c3_ready", req_ready, 3'b100);
        tick();
        idle();
        check_write("rr_c4", 5'd7, 4'd4, 32'h7777_0007);
        tick();
        check("rr_c5_en", rf_write_enable, 1'b0);

        // Reserve x9, then requester 1 retires it (ptr back at 0).
        reserve_valid  = 1'b1;
        reserve_addr   = 5'd9;
        read_reg1_addr = 5'd9;
        read_reg2_addr = 5'd0;
        tick();
        idle();
        check("res9_busy1", reg1_busy, 1'b1);
        check("res9_vec",   busy_vector, 32'h0000_0200);
        check("res9_x0",    reg2_busy, 1'b0);
        set_req(1, 5'd9, 4'd4, 32'hDEAD_BEEF);
        #1;
        check("res9_ready", req_ready, 3'b010);
        check("res9_busy_pre", reg1_busy, 1'b1);
        tick();
        idle();
        check("res9_busy_post", reg1_busy, 1'b0);
        check_write("res9_wr", 5'd9, 4'd4, 32'hDEAD_BEEF);

        // Same-cycle reserve and retire of x3: set wins (ptr 2, only req0 -> wraps).
        reserve_valid = 1'b1;
        reserve_addr  = 5'd3;
        set_req(0, 5'd3, 4'd2, 32'h0000_3333);
        #1;
        check("same_ready", req_ready, 3'b001);
        tick();
        idle();
        check("same_vec", busy_vector, 32'h0000_0008);
        check_write("same_wr", 5'd3, 4'd2, 32'h0000_3333);

        // Write to x0 (ptr 1 -> req2), then width 3 from req0 (ptr 0).
        set_req(2, 5'd0, 4'd4, 32'h0BAD_0000);
        #1;
        check("x0_ready", req_ready, 3'b100);
        tick();
        idle();
        check("x0_en",   rf_write_enable, 1'b0);
        check("x0_werr", width_error, 1'b0);
        set_req(0, 5'd10, 4'd3, 32'h0BAD_0003);
        #1;
        check("w3_ready", req_ready, 3'b001);
        tick();
        idle();
        check("w3_en",   rf_write_enable, 1'b0);
        check("w3_werr", width_error, 1'b1);
        tick();
        check("w3_sticky", width_error, 1'b1);

        // Busy x4 and x8, a write registered, then flush with req2 valid.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd4;
        tick();
        reserve_addr  = 5'd8;
        tick();
        idle();
        check("fl_vec_pre", busy_vector, 32'h0000_0118);
        set_req(0, 5'd12, 4'd2, 32'h0000_1234);
        tick();
        idle();
        flush         = 1'b1;
        reserve_valid = 1'b1;
        reserve_addr  = 5'd4;
        set_req(2, 5'd13, 4'd4, 32'hFFFF_0013);
        #1;
        check("fl_ready", req_ready, 3'b000);
        check_write("fl_prior", 5'd12, 4'd2, 32'h0000_1234);
        tick();
        idle();
        check("fl_vec_post", busy_vector, 32'h0);
        check("fl_en_post",  rf_write_enable, 1'b0);
        check("fl_werr",     width_error, 1'b1);
        // Pointer held at 1 through flush: with req0 and req2 valid, req2 wins.
        set_req(0, 5'd21, 4'd4, 32'h0000_0021);
        set_req(2, 5'd20, 4'd1, 32'h0000_0020);
        #1;
        check("fl_ptr_hold", req_ready, 3'b100);
        tick();
        idle();
        check_write("fl_after", 5'd20, 4'd1, 32'h0000_0020);

        // Asynchronous reset mid-cycle during a handshake.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd7;
        tick();
        idle();
        check("ar_vec_pre", busy_vector, 32'h0000_0080);
        set_req(1, 5'd15, 4'd4, 32'hCAFE_F00D);
        #1;
        check("ar_ready_pre", req_ready, 3'b010);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ready", req_ready, 3'b000);
        check("ar_en",    rf_write_enable, 1'b0);
        check("ar_vec",   busy_vector, 32'h0);
        check("ar_werr",  width_error, 1'b0);
        check("ar_data",  rf_write_data, 32'h0);
        tick();
        idle();
        #2;
        reset = 1'b0;
        tick();
        check("ar_rel_en1", rf_write_enable, 1'b0);
        check("ar_rel_addr", rf_write_reg_addr, 5'd0);
        tick();
        check("ar_rel_en2", rf_write_enable, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
